enable_sequencer: RTL and testbench

//  Parametrised, registered successor to the 1-of-8 enable demux. Routes a write/enable

---
 rtl/enable_sequencer_pkg.sv | 14 +
 rtl/enable_sequencer_if.sv | 31 +++
 rtl/enable_sequencer_onehot_decode.sv | 18 +
 rtl/enable_sequencer.sv | 117 +++++++++++
 tb/tb_enable_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/enable_sequencer_pkg.sv
// Shared types and default parameters for the enable sequencer slice.
package enable_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_SWEEP = 2'd2
  } seq_state_e;

  localparam int DEF_SEL_W   = 3;
  localparam int DEF_NUM_OUT = 8;
  localparam int DEF_LEN_W   = 4;

endpackage

// File: rtl/enable_sequencer_if.sv
// Request/enable bundle between the control unit (master) and the sequencer (slave).
interface enable_sequencer_if
  import enable_sequencer_pkg::*;
#(
  parameter int SEL_W   = DEF_SEL_W,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int LEN_W   = DEF_LEN_W
) ();

  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_sel;
  logic [LEN_W-1:0]   req_len;
  logic               req_sweep;
  logic [NUM_OUT-1:0] out_en;
  logic [SEL_W-1:0]   active_sel;
  logic               busy;
  logic               done;
  logic               err_sel;

  modport master (
    output req_valid, req_sel, req_len, req_sweep,
    input  req_ready, out_en, active_sel, busy, done, err_sel
  );

  modport slave (
    input  req_valid, req_sel, req_len, req_sweep,
    output req_ready, out_en, active_sel, busy, done, err_sel
  );

endinterface

// File: rtl/enable_sequencer_onehot_decode.sv
// Combinational index to one-hot decoder; out-of-range indices decode to all-zero.
module onehot_decode #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   idx,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = en && (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/enable_sequencer.sv
// Routes a request to one registered one-hot enable for a programmable hold time,
// or sweeps every enable in turn (register-file clear).
module enable_sequencer
  import enable_sequencer_pkg::*;
#(
  parameter int SEL_W   = DEF_SEL_W,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int LEN_W   = DEF_LEN_W
) (
  input logic               clk,
  input logic               reset,
  enable_sequencer_if.slave bus
);

  localparam logic [SEL_W:0]   NUM_OUT_X = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  seq_state_e         state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   len_eff;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   dec_idx;
  logic [NUM_OUT-1:0] dec_onehot;
  logic               sel_ok;

  // The decoder sees the index about to be driven: the request target while idle,
  // otherwise the next sweep channel.
  always_comb begin
    len_eff = (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;
    sel_ok  = {1'b0, bus.req_sel} < NUM_OUT_X;
    dec_idx = idx + SEL_W'(1);
    if (state == ST_IDLE) begin
      dec_idx = bus.req_sweep ? '0 : bus.req_sel;
    end
  end

  onehot_decode #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) u_decode (
    .en    (1'b1),
    .idx   (dec_idx),
    .onehot(dec_onehot)
  );

  assign bus.req_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      len_reg        <= '0;
      idx            <= '0;
      bus.out_en     <= '0;
      bus.active_sel <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err_sel    <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.err_sel <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_sweep || sel_ok) begin
              state          <= bus.req_sweep ? ST_SWEEP : ST_PULSE;
              idx            <= dec_idx;
              cnt            <= len_eff - LEN_W'(1);
              len_reg        <= len_eff;
              bus.out_en     <= dec_onehot;
              bus.active_sel <= dec_idx;
              bus.busy       <= 1'b1;
              bus.done       <= !bus.req_sweep && (len_eff == LEN_W'(1));
            end else begin
              bus.err_sel <= 1'b1;
            end
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            state          <= ST_IDLE;
            bus.out_en     <= '0;
            bus.active_sel <= '0;
            bus.busy       <= 1'b0;
          end else begin
            cnt      <= cnt - LEN_W'(1);
            bus.done <= (cnt == LEN_W'(1));
          end
        end
        ST_SWEEP: begin
          if (cnt != '0) begin
            cnt      <= cnt - LEN_W'(1);
            bus.done <= (cnt == LEN_W'(1)) && (idx == LAST_IDX);
          end else if (idx == LAST_IDX) begin
            state          <= ST_IDLE;
            idx            <= '0;
            bus.out_en     <= '0;
            bus.active_sel <= '0;
            bus.busy       <= 1'b0;
          end else begin
            // Step straight to the next channel so there is no gap between enables.
            idx            <= dec_idx;
            cnt            <= len_reg - LEN_W'(1);
            bus.out_en     <= dec_onehot;
            bus.active_sel <= dec_idx;
            bus.done       <= (dec_idx == LAST_IDX) && (len_reg == LEN_W'(1));
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enable_sequencer.sv
// Scoreboard bench for enable_sequencer: an 8-output instance and a 6-output instance.
module tb_enable_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  enable_sequencer_if #(.SEL_W(3), .NUM_OUT(8), .LEN_W(4)) bus_a ();
  enable_sequencer_if #(.SEL_W(3), .NUM_OUT(6), .LEN_W(4)) bus_b ();

  enable_sequencer #(.SEL_W(3), .NUM_OUT(8), .LEN_W(4)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  enable_sequencer #(.SEL_W(3), .NUM_OUT(6), .LEN_W(4)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.slave)
  );

  typedef struct {
    int         dut;
    logic [7:0] en;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic pushExp(input int dut, input logic [7:0] en, input int sel,
                         input logic busy, input logic done, input logic err,
                         input logic ready);
    exp_t e;
    e.dut   = dut;
    e.en    = en;
    e.sel   = 3'(sel);
    e.busy  = busy;
    e.done  = done;
    e.err   = err;
    e.ready = ready;
    sb.push_back(e);
  endtask

  task automatic pushIdle(input int dut, input logic err);
    pushExp(dut, 8'h00, 0, 1'b0, 1'b0, err, 1'b1);
  endtask

  // Reference behaviour: len' enabled cycles per channel, then one idle cycle.
  task automatic modelPulse(input int dut, input int sel, input int len);
    int lp;
    lp = (len == 0) ? 1 : len;
    for (int c = 1; c <= lp; c++) begin
      pushExp(dut, 8'b1 << sel, sel, 1'b1, c == lp, 1'b0, 1'b0);
    end
    pushIdle(dut, 1'b0);
  endtask

  task automatic modelSweep(input int dut, input int n, input int len);
    int lp;
    lp = (len == 0) ? 1 : len;
    for (int ch = 0; ch < n; ch++) begin
      for (int c = 1; c <= lp; c++) begin
        pushExp(dut, 8'b1 << ch, ch, 1'b1, (ch == n - 1) && (c == lp), 1'b0, 1'b0);
      end
    end
    pushIdle(dut, 1'b0);
  endtask

  task automatic cmp(input string tag, input int dut, input logic [7:0] obs,
                     input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s dut%0d at %0t: observed %0h expected %0h", tag, dut, $time, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] a_en;
    logic [2:0] a_sel;
    logic       a_busy, a_done, a_err, a_ready;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected at least 1");
    end else begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        a_en    = bus_a.out_en;
        a_sel   = bus_a.active_sel;
        a_busy  = bus_a.busy;
        a_done  = bus_a.done;
        a_err   = bus_a.err_sel;
        a_ready = bus_a.req_ready;
      end else begin
        a_en    = {2'b00, bus_b.out_en};
        a_sel   = bus_b.active_sel;
        a_busy  = bus_b.busy;
        a_done  = bus_b.done;
        a_err   = bus_b.err_sel;
        a_ready = bus_b.req_ready;
      end
      cmp("out_en", e.dut, a_en, e.en);
      cmp("active_sel", e.dut, {5'b0, a_sel}, {5'b0, e.sel});
      cmp("busy", e.dut, {7'b0, a_busy}, {7'b0, e.busy});
      cmp("done", e.dut, {7'b0, a_done}, {7'b0, e.done});
      cmp("err_sel", e.dut, {7'b0, a_err}, {7'b0, e.err});
      cmp("req_ready", e.dut, {7'b0, a_ready}, {7'b0, e.ready});
    end
  endtask

  task automatic driveReq(input int dut, input logic v, input logic sw,
                          input int sel, input int len);
    if (dut == 0) begin
      bus_a.req_valid = v;
      bus_a.req_sweep = sw;
      bus_a.req_sel   = 3'(sel);
      bus_a.req_len   = 4'(len);
    end else begin
      bus_b.req_valid = v;
      bus_b.req_sweep = sw;
      bus_b.req_sel   = 3'(sel);
      bus_b.req_len   = 4'(len);
    end
  endtask

  // Drives one request for a single cycle, queues its expected trace, then drains it.
  task automatic applyStimulus(input int dut, input logic sw, input int sel, input int len);
    int n;
    int guard;
    n = (dut == 0) ? 8 : 6;
    driveReq(dut, 1'b1, sw, sel, len);
    if (sw) modelSweep(dut, n, len);
    else if (sel < n) modelPulse(dut, sel, len);
    else pushIdle(dut, 1'b1);
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(posedge clk);
      #1;
      if (guard == 0) driveReq(dut, 1'b0, 1'b0, 0, 0);
      checkOutput();
      guard++;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL drain_timeout: observed %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    driveReq(0, 1'b0, 1'b0, 0, 0);
    driveReq(1, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    pushIdle(0, 1'b0);
    pushIdle(1, 1'b0);
    checkOutput();
    checkOutput();
    @(posedge clk);
    #1;
    pushIdle(0, 1'b0);
    checkOutput();

    applyStimulus(0, 1'b0, 5, 3);
    applyStimulus(0, 1'b0, 2, 0);
    applyStimulus(0, 1'b0, 7, 15);

    applyStimulus(1, 1'b0, 7, 2);
    applyStimulus(1, 1'b0, 6, 1);
    applyStimulus(1, 1'b0, 5, 1);

    applyStimulus(0, 1'b1, 0, 2);
    applyStimulus(1, 1'b1, 7, 1);

    // Reset lands in the second sweep cycle; a held request while busy must be ignored.
    driveReq(0, 1'b1, 1'b1, 0, 4);
    pushExp(0, 8'h01, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExp(0, 8'h01, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    driveReq(0, 1'b1, 1'b0, 3, 1);
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b1;
    driveReq(0, 1'b0, 1'b0, 0, 0);
    pushIdle(0, 1'b0);
    pushIdle(1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput();
    checkOutput();
    repeat (3) begin
      pushIdle(0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
